// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding and width helper for the matrix-vector controller
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MULT, DRAIN, SEND, WAIT_NEW} mm_state_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mm_wrap_counter.sv
// mm_wrap_counter: modulo-MAX counter with sync clear and terminal-count flag
module mm_wrap_counter
  import matmul_pkg::*;
#(
  parameter int MAX = 8,
  localparam int W = clog2_min1(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  assign at_max = cnt == W'(MAX - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= at_max ? '0 : cnt + 1'b1;
endmodule

// File: rtl/matmul_ctrl_param.sv
// matmul_ctrl_param: weight-stationary y=W*x controller with MAC pipeline delay, row tagging and abort
module matmul_ctrl_param
  import matmul_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int ACC_DELAY = 1,
  localparam int XW = clog2_min1(COLS),
  localparam int WW = clog2_min1(ROWS * COLS),
  localparam int RW = clog2_min1(ROWS),
  localparam int DW = clog2_min1(ACC_DELAY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  input  logic          new_matrix,
  input  logic          soft_clear,
  input  logic          output_ready,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [WW-1:0] addr_w,
  output logic          wr_en_w,
  output logic          clear_acc,
  output logic          en_acc,
  output logic          input_ready,
  output logic          output_valid,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          busy
);
  mm_state_t state;
  logic [WW-1:0] w_cnt;
  logic [XW-1:0] col;
  logic [RW-1:0] row;
  logic [DW-1:0] d_cnt;
  logic w_max, c_max, r_max, d_max;
  logic in_w, in_x, accept, en_acc_q;
  logic [ACC_DELAY-1:0] en_sr, sr_next;

  // the first word of a new load is taken directly in WAIT_NEW, so it counts as a load beat
  assign in_w = input_valid & ~soft_clear & (state == LOAD_W || (state == WAIT_NEW && new_matrix));
  assign in_x = input_valid & ~soft_clear & (state == LOAD_X || (state == WAIT_NEW && !new_matrix));
  assign accept = state == SEND && output_ready;
  assign en_acc_q = state == MULT;

  assign wr_en_w = in_w;
  assign wr_en_x = in_x;
  assign addr_w = (state == LOAD_W || state == MULT) ? w_cnt : '0;
  assign addr_x = (state == LOAD_X || state == MULT) ? col : '0;
  assign input_ready = state == LOAD_W || state == LOAD_X || state == WAIT_NEW;
  assign clear_acc = state == IDLE || accept;
  assign output_valid = state == SEND;
  assign out_row = output_valid ? row : '0;
  assign out_last = output_valid & r_max;
  assign busy = state != WAIT_NEW;
  assign en_acc = en_sr[ACC_DELAY-1];

  mm_wrap_counter #(.MAX(ROWS * COLS)) u_w (
    .clk(clk), .rst(rst), .en(in_w | en_acc_q), .clr(soft_clear), .cnt(w_cnt), .at_max(w_max)
  );
  mm_wrap_counter #(.MAX(COLS)) u_col (
    .clk(clk), .rst(rst), .en(in_x | en_acc_q), .clr(soft_clear), .cnt(col), .at_max(c_max)
  );
  mm_wrap_counter #(.MAX(ROWS)) u_row (
    .clk(clk), .rst(rst), .en(accept), .clr(soft_clear), .cnt(row), .at_max(r_max)
  );
  mm_wrap_counter #(.MAX(ACC_DELAY)) u_drain (
    .clk(clk), .rst(rst), .en(state == DRAIN), .clr(soft_clear), .cnt(d_cnt), .at_max(d_max)
  );

  if (ACC_DELAY == 1) begin : g_sr1
    assign sr_next = en_acc_q;
  end else begin : g_srn
    assign sr_next = {en_sr[ACC_DELAY-2:0], en_acc_q};
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) en_sr <= '0;
    else if (soft_clear) en_sr <= '0;
    else en_sr <= sr_next;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else if (soft_clear) state <= IDLE;
    else
      case (state)
        IDLE:     state <= LOAD_W;
        LOAD_W:   if (in_w && w_max) state <= LOAD_X;
        LOAD_X:   if (in_x && c_max) state <= MULT;
        MULT:     if (c_max) state <= DRAIN;
        DRAIN:    if (d_max && d_cnt == DW'(ACC_DELAY - 1)) state <= SEND;
        SEND:     if (accept) state <= r_max ? WAIT_NEW : MULT;
        WAIT_NEW:
          if (in_w) state <= w_max ? LOAD_X : LOAD_W;
          else if (in_x) state <= c_max ? MULT : LOAD_X;
        default:  state <= IDLE;
      endcase
endmodule

// File: tb/tb_matmul_ctrl_param.sv
// tb_matmul_ctrl_param: random-data end-to-end check of y=W*x sequencing plus directed timing cases
module tb_matmul_ctrl_param;
  import matmul_pkg::*;
  localparam int ROWS = 4, COLS = 3, ACC_DELAY = 2, N = ROWS * COLS;
  localparam int XW = clog2_min1(COLS), WW = clog2_min1(N), RW = clog2_min1(ROWS);

  logic clk = 0, rst = 0, iv = 0, nm = 0, sc = 0, ordy = 0;
  logic [XW-1:0] addr_x;
  logic [WW-1:0] addr_w;
  logic [RW-1:0] out_row;
  logic wr_en_x, wr_en_w, clear_acc, en_acc, input_ready, output_valid, out_last, busy;

  logic s_rst = 0, s_iv = 0, s_nm = 0, s_rdy = 0;
  logic [0:0] s_addr_x, s_addr_w, s_out_row;
  logic s_wr_en_x, s_wr_en_w, s_clear_acc, s_en_acc, s_input_ready, s_output_valid, s_out_last, s_busy;

  int din;
  int errors = 0, checks = 0;
  int wref[N], xref[COLS];
  int wm[1<<WW], xm[1<<XW], hist[ACC_DELAY];
  int acc, ecnt, exp_row, wa, xa, p_row;
  bit p_hold;
  logic [9:0] tbl[14];

  always #5 clk = ~clk;

  matmul_ctrl_param #(.ROWS(ROWS), .COLS(COLS), .ACC_DELAY(ACC_DELAY)) dut (
    .clk(clk), .rst(rst), .input_valid(iv), .new_matrix(nm), .soft_clear(sc), .output_ready(ordy),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_w(addr_w), .wr_en_w(wr_en_w), .clear_acc(clear_acc),
    .en_acc(en_acc), .input_ready(input_ready), .output_valid(output_valid), .out_row(out_row),
    .out_last(out_last), .busy(busy)
  );

  matmul_ctrl_param #(.ROWS(1), .COLS(1), .ACC_DELAY(1)) dut_s (
    .clk(clk), .rst(s_rst), .input_valid(s_iv), .new_matrix(s_nm), .soft_clear(1'b0), .output_ready(s_rdy),
    .addr_x(s_addr_x), .wr_en_x(s_wr_en_x), .addr_w(s_addr_w), .wr_en_w(s_wr_en_w), .clear_acc(s_clear_acc),
    .en_acc(s_en_acc), .input_ready(s_input_ready), .output_valid(s_output_valid), .out_row(s_out_row),
    .out_last(s_out_last), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int yref(input int r);
    int s = 0;
    for (int c = 0; c < COLS; c++) s += wref[r*COLS+c] * xref[c];
    return s;
  endfunction

  // reference datapath: buffers, ACC_DELAY product pipeline and accumulator driven by the DUT strobes
  always @(negedge clk) begin
    if (!rst || sc) begin
      acc = 0; ecnt = 0; exp_row = 0; wa = 0; xa = 0; p_hold = 0;
      for (int i = 0; i < ACC_DELAY; i++) hist[i] = 0;
    end else begin
      if (wr_en_w) begin
        chk("w_addr", 32'(addr_w), wa); chk("w_beat", iv, 1);
        wm[addr_w] = din; wa = (wa + 1) % N;
      end
      if (wr_en_x) begin
        chk("x_addr", 32'(addr_x), xa); chk("x_beat", iv, 1);
        xm[addr_x] = din; xa = (xa + 1) % COLS;
      end
      if (p_hold) begin
        chk("hold_valid", output_valid, 1); chk("hold_row", 32'(out_row), p_row);
      end
      if (en_acc) begin acc += hist[ACC_DELAY-1]; ecnt++; end
      if (output_valid) begin
        chk("row", 32'(out_row), exp_row);
        chk("last", out_last, 32'(exp_row == ROWS - 1));
        chk("clear_on_accept", clear_acc, ordy);
        if (ordy) begin
          chk("y", acc, yref(exp_row)); chk("macs", ecnt, COLS);
          exp_row = (exp_row + 1) % ROWS;
        end
      end
      p_hold = output_valid && !ordy; p_row = 32'(out_row);
      for (int i = ACC_DELAY - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = wm[addr_w] * xm[addr_x];
      if (clear_acc) begin acc = 0; ecnt = 0; end
    end
  end

  task automatic feed(input int n, input bit is_w, input bit rnd);
    int k = 0;
    for (int g = 0; g < 500 && k < n; g++) begin
      iv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      din = $urandom_range(1, 255);
      @(negedge clk);
      chk(is_w ? "wr_en_w" : "wr_en_x", is_w ? wr_en_w : wr_en_x, iv && input_ready);
      chk("wr_other", is_w ? wr_en_x : wr_en_w, 0);
      if (iv && input_ready) begin
        if (is_w) wref[k] = din; else xref[k] = din;
        k++;
      end
      @(posedge clk); #1;
    end
    iv = 0;
    chk("feed_beats", k, n);
  endtask

  task automatic wait_valid();
    bit found = 0;
    for (int g = 0; g < 200 && !found; g++) begin
      @(negedge clk);
      if (output_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("valid_timeout", found, 1);
  endtask

  task automatic collect(input int stall);
    for (int r = 0; r < ROWS; r++) begin
      wait_valid();
      repeat (stall) begin @(posedge clk); #1; @(negedge clk); end
      @(posedge clk); #1; ordy = 1;
      @(negedge clk);
      @(posedge clk); #1; ordy = 0;
    end
    @(negedge clk);
    chk("idle_busy", busy, 0); chk("idle_ready", input_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1); chk({tag, "_clr"}, clear_acc, 1);
    chk({tag, "_ir"}, input_ready, 0); chk({tag, "_ov"}, output_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk_idle("reset"); chk("reset_en", en_acc, 0); chk("reset_wrw", wr_en_w, 0);
    chk("reset_aw", 32'(addr_w), 0); chk("reset_ax", 32'(addr_x), 0);
    @(posedge clk); #1 rst = 1; nm = 1;
    // full load, then MULT/DRAIN/SEND cycle timing
    feed(N, 1, 0); feed(COLS, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t_en_acc", en_acc, 32'(i >= 2 && i <= 4));
      chk("t_valid", output_valid, 32'(i == 5));
      if (i < 3) begin chk("t_aw", 32'(addr_w), i); chk("t_ax", 32'(addr_x), i); end
      @(posedge clk); #1;
    end
    collect(0);
    // new x only, stalled outputs
    nm = 0; feed(COLS, 0, 0); collect(5);
    // reload W
    nm = 1; feed(N, 1, 0); feed(COLS, 0, 0); collect(0);
    // random input_valid
    feed(N, 1, 1); feed(COLS, 0, 1); collect(2);
    // soft_clear in MULT, next load must be W even with new_matrix=0
    nm = 0; feed(COLS, 0, 0);
    sc = 1; @(negedge clk); @(posedge clk); #1 sc = 0;
    for (int i = 0; i < ACC_DELAY; i++) begin
      @(negedge clk);
      chk("sc_mult_en", en_acc, 0);
      if (i == 0) chk_idle("sc_mult");
      @(posedge clk); #1;
    end
    feed(N, 1, 0); feed(COLS, 0, 0); collect(1);
    // soft_clear in SEND
    feed(COLS, 0, 0); wait_valid();
    @(posedge clk); #1 sc = 1;
    @(negedge clk); @(posedge clk); #1 sc = 0;
    @(negedge clk); chk_idle("sc_send"); chk("sc_send_en", en_acc, 0);
    @(posedge clk); #1;
    feed(N, 1, 0); feed(1, 0, 0);
    // async reset mid LOAD_X
    rst = 0; #1;
    chk_idle("arst"); chk("arst_en", en_acc, 0); chk("arst_wrx", wr_en_x, 0);
    @(negedge clk); @(posedge clk); #1 rst = 1;
    feed(N, 1, 0); feed(COLS, 0, 0); collect(3);
    // ROWS=COLS=ACC_DELAY=1 instance: {iv,nm,rdy} -> {ir,wrw,wrx,en,ov,busy,clr}
    tbl = '{10'b110_0000011, 10'b110_1100010, 10'b110_1010010, 10'b000_0000010,
            10'b000_0001010, 10'b001_0000111, 10'b100_1010000, 10'b000_0000010,
            10'b000_0001010, 10'b000_0000110, 10'b001_0000111, 10'b110_1100000,
            10'b100_1010010, 10'b000_0000010};
    s_rst = 1;
    for (int i = 0; i < 14; i++) begin
      {s_iv, s_nm, s_rdy} = tbl[i][9:7];
      @(negedge clk);
      chk($sformatf("small_%0d", i),
          {s_input_ready, s_wr_en_w, s_wr_en_x, s_en_acc, s_output_valid, s_busy, s_clear_acc}, tbl[i][6:0]);
      if (s_output_valid) chk("small_last", s_out_last, 1);
      @(posedge clk); #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
